deadlock_idx0_monitor: RTL and testbench

Deadlock detector for the top kernel instance (index 0) of the HLS simulation bench. It watches the kernel's AXI-stream blocking flags and the idle flag of its single pipelined child loop (index 1). It raises a registered `block` flag whenever the kernel is stalled on a stream. It sits under the kernel monitor top, whose display logic reports the rising edge of `block`.

---
 rtl/deadlock_mon_pkg.sv | 16 +
 rtl/deadlock_idx1_monitor.sv | 25 ++
 rtl/deadlock_idx0_monitor.sv | 50 +++++
 tb/tb_deadlock_idx0_monitor.sv | 175 +++++++++++++++++
 4 files changed

// File: rtl/deadlock_mon_pkg.sv
// Shared widths, bit positions and helper terms for the kernel deadlock monitors.
package deadlock_mon_pkg;

  localparam int unsigned AXIS_W    = 2;
  localparam int unsigned INST_W    = 2;
  localparam int unsigned INSTBLK_W = 1;

  localparam int unsigned IDX_CUR_AXIS = 0;
  localparam int unsigned IDX_CHILD1   = 1;

  // A child counts as stalled only while it is active and its stream is blocked.
  function automatic logic child_stalled(input logic axis_blk, input logic idle);
    return axis_blk & ~idle;
  endfunction

endpackage

// File: rtl/deadlock_idx1_monitor.sv
// Sub-monitor for the pipelined child loop (index 1): registers "active and stalled on input".
module deadlock_idx1_monitor
  import deadlock_mon_pkg::*;
(
  input  logic clock,
  input  logic reset,
  input  logic axis_blk,
  input  logic idle,
  output logic block
);

  logic idx1_block_r;

  // Child stall register, cleared asynchronously.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      idx1_block_r <= 1'b0;
    end else begin
      idx1_block_r <= child_stalled(axis_blk, idle);
    end
  end

  assign block = idx1_block_r;

endmodule

// File: rtl/deadlock_idx0_monitor.sv
// Deadlock monitor for the top kernel instance: ORs its own stream stall with the child's.
module deadlock_idx0_monitor
  import deadlock_mon_pkg::*;
(
  input  logic                 clock,
  input  logic                 reset,
  input  logic [AXIS_W-1:0]    axis_block_sigs,
  input  logic [INST_W-1:0]    inst_idle_sigs,
  input  logic [INSTBLK_W-1:0] inst_block_sigs,
  output logic                 block
);

  logic idx1_block_s;
  logic cur_axis_s;
  logic child_blk_s;
  logic par_inst_s;
  logic next_block_s;
  logic block_r;
  logic unused_reserved_s;

  deadlock_idx1_monitor u_idx1 (
    .clock    (clock),
    .reset    (reset),
    .axis_blk (axis_block_sigs[IDX_CHILD1]),
    .idle     (inst_idle_sigs[IDX_CHILD1]),
    .block    (idx1_block_s)
  );

  // The child term is gated by the live stream flag so a stale stall never counts.
  always_comb begin
    cur_axis_s   = axis_block_sigs[IDX_CUR_AXIS];
    child_blk_s  = idx1_block_s & axis_block_sigs[IDX_CHILD1];
    par_inst_s   = 1'b0;
    next_block_s = cur_axis_s | child_blk_s | par_inst_s;
  end

  // Registered deadlock flag.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      block_r <= 1'b0;
    end else begin
      block_r <= next_block_s;
    end
  end

  assign block = block_r;

  assign unused_reserved_s = ^{inst_idle_sigs[IDX_CUR_AXIS], inst_block_sigs};

endmodule

// File: tb/tb_deadlock_idx0_monitor.sv
// Directed plus random bench for deadlock_idx0_monitor against a history-based reference model.
module tb_deadlock_idx0_monitor;

  logic       clock;
  logic       reset;
  logic [1:0] axis_block_sigs;
  logic [1:0] inst_idle_sigs;
  logic [0:0] inst_block_sigs;
  logic       block;

  int checks;
  int fails;

  // Samples of the inputs seen at each rising edge since the last reset release.
  logic hist_a0[$];
  logic hist_a1[$];
  logic hist_idle1[$];

  deadlock_idx0_monitor dut (
    .clock           (clock),
    .reset           (reset),
    .axis_block_sigs (axis_block_sigs),
    .inst_idle_sigs  (inst_idle_sigs),
    .inst_block_sigs (inst_block_sigs),
    .block           (block)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  function automatic logic model_block();
    int n;
    logic child;
    n = hist_a0.size();
    if (n == 0) return 1'b0;
    child = 1'b0;
    if (n >= 2)
      child = hist_a1[n-2] & ~hist_idle1[n-2] & hist_a1[n-1];
    return hist_a0[n-1] | child;
  endfunction

  task automatic clear_hist();
    hist_a0.delete();
    hist_a1.delete();
    hist_idle1.delete();
  endtask

  task automatic check(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: block=%0b expected=%0b", tag, obs, exp);
    end
  endtask

  // Drive inputs, take one edge, update the model, then check 1 ns later.
  task automatic step(input logic [1:0] a, input logic [1:0] idl, input logic ib, input string tag);
    axis_block_sigs = a;
    inst_idle_sigs  = idl;
    inst_block_sigs = ib;
    @(posedge clock);
    if (reset) begin
      hist_a0.push_back(a[0]);
      hist_a1.push_back(a[1]);
      hist_idle1.push_back(idl[1]);
      if (hist_a0.size() > 2) begin
        void'(hist_a0.pop_front());
        void'(hist_a1.pop_front());
        void'(hist_idle1.pop_front());
      end
    end else begin
      clear_hist();
    end
    #1;
    check(tag, block, model_block());
  endtask

  initial begin
    checks = 0;
    fails  = 0;
    clear_hist();

    // Reset held with all inputs high.
    reset = 1'b0;
    axis_block_sigs = 2'b11;
    inst_idle_sigs  = 2'b11;
    inst_block_sigs = 1'b1;
    #2;
    check("reset_async", block, 1'b0);
    for (int i = 0; i < 3; i++) step(2'b11, 2'b11, 1'b1, "reset_hold");

    // Release with current-stream block: block after the first edge.
    axis_block_sigs = 2'b01;
    inst_idle_sigs  = 2'b00;
    inst_block_sigs = 1'b0;
    reset = 1'b1;
    step(2'b01, 2'b00, 1'b0, "release_first_edge");
    check("release_is_one", block, 1'b1);
    step(2'b00, 2'b00, 1'b0, "release_clear");
    step(2'b00, 2'b00, 1'b0, "idle_gap");

    // Three-cycle pulse on the current stream.
    for (int i = 0; i < 3; i++) step(2'b01, 2'b00, 1'b0, "cur_pulse_hi");
    for (int i = 0; i < 3; i++) step(2'b00, 2'b00, 1'b0, "cur_pulse_lo");

    // Child path held: 0 after the first edge, 1 from the second onward.
    step(2'b10, 2'b00, 1'b0, "child_edge1");
    check("child_edge1_zero", block, 1'b0);
    step(2'b10, 2'b00, 1'b0, "child_edge2");
    check("child_edge2_one", block, 1'b1);
    for (int i = 0; i < 3; i++) step(2'b10, 2'b00, 1'b0, "child_hold");
    for (int i = 0; i < 3; i++) step(2'b00, 2'b00, 1'b0, "child_release");

    // Single-cycle child pulse never sets block.
    step(2'b10, 2'b00, 1'b0, "child_pulse");
    for (int i = 0; i < 3; i++) begin
      step(2'b00, 2'b00, 1'b0, "child_pulse_after");
      check("child_pulse_zero", block, 1'b0);
    end

    // Idle masking.
    for (int i = 0; i < 10; i++) begin
      step(2'b10, 2'b10, 1'b0, "idle_mask");
      check("idle_mask_zero", block, 1'b0);
    end

    // Reserved inputs toggled randomly have no effect.
    for (int i = 0; i < 10; i++) begin
      step(2'b00, {1'b0, 1'($urandom_range(0, 1))}, 1'($urandom_range(0, 1)), "reserved");
      check("reserved_zero", block, 1'b0);
    end

    // Both paths together: OR semantics.
    for (int i = 0; i < 3; i++) step(2'b11, 2'b00, 1'b0, "both_paths");
    step(2'b10, 2'b00, 1'b0, "both_child_only");
    check("both_child_holds", block, 1'b1);
    step(2'b00, 2'b00, 1'b0, "both_clear");

    // Async reset mid-block on the current-stream path.
    step(2'b01, 2'b00, 1'b0, "rst0_set");
    step(2'b01, 2'b00, 1'b0, "rst0_set2");
    #3 reset = 1'b0;
    #1;
    clear_hist();
    check("rst0_async_drop", block, 1'b0);
    step(2'b01, 2'b00, 1'b0, "rst0_hold");
    reset = 1'b1;
    step(2'b01, 2'b00, 1'b0, "rst0_requal");
    check("rst0_requal_one", block, 1'b1);

    // Async reset mid-block on the child path.
    step(2'b10, 2'b00, 1'b0, "rst1_set");
    step(2'b10, 2'b00, 1'b0, "rst1_set2");
    step(2'b10, 2'b00, 1'b0, "rst1_set3");
    #3 reset = 1'b0;
    #1;
    clear_hist();
    check("rst1_async_drop", block, 1'b0);
    step(2'b10, 2'b00, 1'b0, "rst1_hold");
    reset = 1'b1;
    step(2'b10, 2'b00, 1'b0, "rst1_edge1");
    check("rst1_edge1_zero", block, 1'b0);
    step(2'b10, 2'b00, 1'b0, "rst1_edge2");
    check("rst1_edge2_one", block, 1'b1);

    // Random stimulus against the model.
    for (int i = 0; i < 300; i++) begin
      step(2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), "random");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
